// File: rtl/gate_pkg.sv
// Shared definitions for the gate pipeline: operation encoding used by the ALU and its wrapper.
package gate_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_AND   = 3'd0;
  localparam op_t OP_OR    = 3'd1;
  localparam op_t OP_XOR   = 3'd2;
  localparam op_t OP_XNOR  = 3'd3;
  localparam op_t OP_NAND  = 3'd4;
  localparam op_t OP_NOR   = 3'd5;
  localparam op_t OP_NOTA  = 3'd6;
  localparam op_t OP_PASSA = 3'd7;

endpackage

// File: rtl/gate_alu.sv
// Combinational bitwise operation selector; every op code maps to a defined function of a and b.
module gate_alu
  import gate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  op_t              op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y_next
);

  always_comb begin
    // NOTE: y_next gets a default before the case so no path leaves it unassigned (no latch).
    y_next = a;
    case (op)
      OP_AND:   y_next = a & b;
      OP_OR:    y_next = a | b;
      OP_XOR:   y_next = a ^ b;
      OP_XNOR:  y_next = ~(a ^ b);
      OP_NAND:  y_next = ~(a & b);
      OP_NOR:   y_next = ~(a | b);
      OP_NOTA:  y_next = ~a;
      OP_PASSA: y_next = a;
      default:  y_next = a;
    endcase
  end

endmodule

// File: rtl/gate_unit_pipe.sv
// Registered gate stage: one-deep valid/ready output register around gate_alu, with result flags
// and a saturating count of delivered results.
module gate_unit_pipe
  import gate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_t              op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             y_par,
  output logic             y_zero,
  output logic             y_ones,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] ops_done
);

  logic [WIDTH-1:0] alu_y;
  logic [WIDTH-1:0] y_q, y_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;
  logic             handoff;

  // The register frees up in the same cycle the consumer takes it, giving full throughput.
  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign handoff  = valid_q && out_ready;

  gate_alu #(.WIDTH(WIDTH)) u_alu (
    .op    (op),
    .a     (a),
    .b     (b),
    .y_next(alu_y)
  );

  always_comb begin
    y_d     = y_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    // y only loads on an accepted beat, so idle-cycle X on a/b/op never reaches it.
    if (accept) begin
      y_d     = alu_y;
      valid_d = 1'b1;
    end else if (handoff) begin
      valid_d = 1'b0;
    end
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (handoff && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (rst) begin
      y_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      y_q     <= y_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign y         = y_q;
  assign y_par     = ^y_q;
  assign y_zero    = (y_q == '0);
  assign y_ones    = (y_q == '1);
  assign ops_done  = cnt_q;

endmodule

// File: tb/tb_gate_unit_pipe.sv
// Scoreboard bench for gate_unit_pipe: a per-bit truth-table model predicts each accepted beat,
// a negedge monitor compares results, flags and the delivered-result count.
module tb_gate_unit_pipe;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             y_par;
  logic             y_zero;
  logic             y_ones;
  logic             cnt_clr;
  logic [CNT_W-1:0] ops_done;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             par;
    logic             zero;
    logic             ones;
  } exp_t;

  exp_t             sb[$];
  logic [WIDTH-1:0] ylog[$];
  logic [CNT_W-1:0] cnt_model = '0;
  bit               mon_en = 1'b0;

  // Truth table per op, indexed by {a_bit, b_bit}.
  logic [3:0] lut [8] = '{4'b1000, 4'b1110, 4'b0110, 4'b1001,
                          4'b0111, 4'b0001, 4'b0011, 4'b1100};

  always #5 clk = ~clk;

  gate_unit_pipe #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .op       (op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y        (y),
    .y_par    (y_par),
    .y_zero   (y_zero),
    .y_ones   (y_ones),
    .cnt_clr  (cnt_clr),
    .ops_done (ops_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic exp_t model_beat(input logic [2:0] o, input logic [WIDTH-1:0] x,
                                      input logic [WIDTH-1:0] w);
    exp_t e;
    int   n;
    logic [3:0] row;
    n   = 0;
    row = lut[o];
    for (int i = 0; i < WIDTH; i++) begin
      e.y[i] = row[{x[i], w[i]}];
      if (e.y[i]) n++;
    end
    e.par  = n[0];
    e.zero = (n == 0);
    e.ones = (n == WIDTH);
    return e;
  endfunction

  // Monitor: outputs are compared mid-cycle; model state is advanced for the coming edge.
  always @(negedge clk) begin
    if (mon_en) begin
      check("ops_done", ops_done, cnt_model);
      check("in_ready", in_ready, !out_valid || out_ready);
      if (rst) begin
        sb.delete();
        cnt_model = '0;
      end else begin
        if (out_valid && out_ready) begin
          check("sb_depth", sb.size(), 1);
          if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            check("y", y, e.y);
            check("y_par", y_par, e.par);
            check("y_zero", y_zero, e.zero);
            check("y_ones", y_ones, e.ones);
          end
          ylog.push_back(y);
          if (cnt_model != '1) cnt_model = cnt_model + 1'b1;
        end
        if (cnt_clr) cnt_model = '0;
        if (in_valid && in_ready) sb.push_back(model_beat(op, a, b));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [2:0] o, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] w);
    op       = o;
    a        = x;
    b        = w;
    in_valid = 1'b1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    a        = 'x;
    b        = 'x;
    op       = 'x;
  endtask

  logic [WIDTH-1:0] sweep_exp [8] = '{8'hC0, 8'hFC, 8'h3C, 8'hC3, 8'h3F, 8'h03, 8'h0F, 8'hF0};

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    cnt_clr   = 1'b0;
    idle();
    step();
    mon_en = 1'b1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_y", y, 0);
    check("rst_y_par", y_par, 0);
    check("rst_y_zero", y_zero, 1);
    check("rst_y_ones", y_ones, 0);
    check("rst_ops_done", ops_done, 0);
    rst = 1'b0;
    step();
    check("idle_x_y", y, 0);
    check("idle_out_valid", out_valid, 0);

    // Single XNOR beat.
    out_ready = 1'b1;
    beat(3'd3, 8'hA5, 8'h0F);
    step();
    idle();
    check("t1_out_valid", out_valid, 1);
    check("t1_y", y, 8'h55);
    check("t1_y_par", y_par, 0);
    check("t1_y_zero", y_zero, 0);
    step();
    check("t1_ops_done", ops_done, 1);
    check("t1_drained", out_valid, 0);

    // Back-to-back sweep of every op.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    ylog.delete();
    for (int i = 0; i < 8; i++) begin
      beat(3'(i), 8'hF0, 8'hCC);
      step();
      check("t2_no_bubble", out_valid, 1);
    end
    idle();
    step();
    check("t2_ops_done", ops_done, 8);
    check("t2_count", ylog.size(), 8);
    for (int i = 0; i < 8 && i < ylog.size(); i++) check("t2_seq", ylog[i], sweep_exp[i]);

    // Backpressure with a second beat waiting.
    out_ready = 1'b0;
    beat(3'd4, 8'hFF, 8'hFF);
    step();
    beat(3'd1, 8'h01, 8'h80);
    for (int i = 0; i < 3; i++) begin
      check("t3_in_ready", in_ready, 0);
      check("t3_out_valid", out_valid, 1);
      check("t3_y_hold", y, 8'h00);
      check("t3_y_zero", y_zero, 1);
      step();
    end
    out_ready = 1'b1;
    step();
    idle();
    check("t3_y_next", y, 8'h81);
    check("t3_valid_next", out_valid, 1);
    step();
    check("t3_drained", out_valid, 0);

    // Counter saturation, then clear winning over a handshake.
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    for (int i = 0; i < 17; i++) begin
      beat(3'd7, 8'(i), 8'h00);
      step();
    end
    idle();
    step();
    check("t4_saturated", ops_done, 4'hF);
    beat(3'd0, 8'h3C, 8'h0F);
    step();
    idle();
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    check("t4_clr_wins", ops_done, 0);

    // Reset while a result is pending.
    beat(3'd6, 8'h55, 8'h00);
    step();
    idle();
    step();
    check("t5_pre_ops", ops_done, 1);
    out_ready = 1'b0;
    beat(3'd5, 8'h00, 8'h00);
    step();
    idle();
    check("t5_pending", out_valid, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5_out_valid", out_valid, 0);
    check("t5_y", y, 0);
    check("t5_ops_done", ops_done, 0);
    check("t5_in_ready", in_ready, 1);
    out_ready = 1'b1;
    beat(3'd2, 8'h0F, 8'hFF);
    step();
    idle();
    check("t5_y_xor", y, 8'hF0);
    check("t5_y_ones", y_ones, 0);
    step();

    check("sb_empty_end", sb.size(), 0);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Watchdog so the run always ends.
  initial begin
    #20000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
